// File: rtl/mult_iter.sv
// Iterative shift-add multiplier for MULT/MULTU: one step per clock,
// signed operands handled as magnitudes with a final conditional negate.
module mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW:0]      acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   upper;
  logic [PW:0]      step;
  logic [PW-1:0]    mag_prod;
  logic             last;

  // -2^(WIDTH-1) negates to itself, which is already the right magnitude
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    upper = acc_q[PW:WIDTH];
    if (mplier_q[0]) begin
      upper = acc_q[PW:WIDTH] + {1'b0, mcand_q};
    end
    step     = {upper, acc_q[WIDTH-1:0]} >> 1;
    mag_prod = step[PW-1:0];
    last     = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          prod_d  = neg_q ? -mag_prod : mag_prod;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = prod_q[PW-1:WIDTH];
  assign lo   = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_iter.sv
// Directed and random checks of mult_iter at WIDTH=32.
module tb_mult_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mult_iter #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  function automatic logic [63:0] ref_mul(
    input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
    end else begin
      sx = {32'b0, x};
      sy = {32'b0, y};
    end
    return sx * sy;
  endfunction

  task automatic do_op(input logic s, input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [63:0] p, output int lat);
    @(negedge clock);
    start = 1'b1; is_signed = s; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    p = {hi, lo};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0", {busy, done, hi, lo});
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      bad++;
      $display("FAIL reset_release got=%h want=0", {busy, done, hi, lo});
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      total++;
      if ({busy, done, hi, lo} !== 66'b0) begin
        bad++;
        $display("FAIL idle_%0d got=%h want=0", i, {busy, done, hi, lo});
      end
    end
  endtask

  task automatic test_unsigned_max();
    int nb, nd, dk;
    logic [63:0] p;
    nb = 0; nd = 0; dk = -1;
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        dk = k;
      end
      @(negedge clock);
    end
    p = {hi, lo};
    total++;
    if (p !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL umax_prod got=%h want=fffffffe00000001", p);
    end
    total++;
    if (nb !== 32) begin
      bad++;
      $display("FAIL umax_busy got=%0d want=32", nb);
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL umax_done_count got=%0d want=1", nd);
    end
    total++;
    if (dk !== 32) begin
      bad++;
      $display("FAIL umax_latency got=%0d want=32", dk);
    end
  endtask

  task automatic test_signed_corners();
    logic [31:0] xa [4];
    logic [31:0] xb [4];
    logic [63:0] xp [4];
    logic [63:0] p;
    int lat;
    xa[0] = 32'h8000_0000; xb[0] = 32'h8000_0000;
    xp[0] = 64'h4000_0000_0000_0000;
    xa[1] = 32'h8000_0000; xb[1] = 32'h0000_0001;
    xp[1] = 64'hFFFF_FFFF_8000_0000;
    xa[2] = 32'hFFFF_FFF9; xb[2] = 32'h0000_0006;
    xp[2] = 64'hFFFF_FFFF_FFFF_FFD6;
    xa[3] = 32'h0000_0000; xb[3] = 32'hFFFF_FFFB;
    xp[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, xa[i], xb[i], p, lat);
      total++;
      if (p !== xp[i] || lat !== 32) begin
        bad++;
        $display("FAIL signed_%0d got=%h lat=%0d want=%h lat=32",
                 i, p, lat, xp[i]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [63:0] p, prior;
    int lat, k;
    logic held_ok;
    do_op(1'b0, 32'd100, 32'd200, p, lat);
    total++;
    if (p !== 64'd20000) begin
      bad++;
      $display("FAIL prime got=%h want=%h", p, 64'd20000);
    end
    prior = {hi, lo};
    held_ok = 1'b1;
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
    @(negedge clock);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; is_signed = 1'b1;
    k = 0;
    while (!done && k < 100) begin
      start = (k == 10);
      if (k == 10) begin
        a = 32'd7; b = 32'd9;
      end
      if ({hi, lo} !== prior) held_ok = 1'b0;
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    total++;
    if ({hi, lo} !== 64'd15 || k !== 32) begin
      bad++;
      $display("FAIL hs_result got=%h lat=%0d want=f lat=32", {hi, lo}, k);
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL hs_hold got=changed want=%h", prior);
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL hs_no_queue got=busy%b done%b want=busy0 done0",
               busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clock);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (k !== 32 || busy !== 1'b0 || {hi, lo} !== 64'd12) begin
      bad++;
      $display("FAIL b2b_first got=%h lat=%0d busy=%b want=c lat=32 busy=0",
               {hi, lo}, k, busy);
    end
    a = 32'd7; b = 32'd8;
    @(negedge clock);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got=busy%b done%b want=busy1 done0",
               busy, done);
    end
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (k !== 32 || {hi, lo} !== 64'd56) begin
      bad++;
      $display("FAIL b2b_second got=%h lat=%0d want=38 lat=32", {hi, lo}, k);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    logic saw;
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0", {busy, done, hi, lo});
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy || {hi, lo} != 64'b0) saw = 1'b1;
    end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL mid_quiet got=activity want=idle");
    end
    do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, p, lat);
    total++;
    if (p !== 64'h0B00_EA4E_242D_2080 || lat !== 32) begin
      bad++;
      $display("FAIL mid_after got=%h lat=%0d want=0b00ea4e242d2080 lat=32",
               p, lat);
    end
  endtask

  task automatic test_random();
    logic [63:0] p, exp;
    logic [31:0] x, y;
    logic s;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 16 == 0) x = 32'h8000_0000;
      if (i % 16 == 1) y = 32'h0;
      exp = ref_mul(s, x, y);
      do_op(s, x, y, p, lat);
      total++;
      if (p !== exp || lat !== 32) begin
        bad++;
        $display("FAIL rand_%0d s=%b a=%h b=%h got=%h lat=%0d want=%h",
                 i, s, x, y, p, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
Name: mult_iter

Overview:
Iterative sequential multiplier, the multiply-side companion of the team's iterative divider, sharing the same start/busy handshake. It accepts two WIDTH-bit operands, signed or unsigned, and produces a 2*WIDTH-bit product using one shift-add step per clock. It sits beside the divider in the ALU multi-cycle path and serves MULT/MULTU. The high half of the product feeds HI and the low half feeds LO.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits; legal range 4..32.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
start  input  1  request; sampled on a rising clock edge.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the product is updated.
hi  output  WIDTH  upper half of the last completed product.
lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, done=0, hi=0, lo=0, iteration counter=0, internal registers=0. Takes effect without a clock edge.
- States: IDLE (busy=0) and RUN (busy=1). No other states.
- Accepting a request: in IDLE, a rising edge with start=1 latches the operands.
  - Magnitudes are stored: |a| and |b| if is_signed=1 and the MSB is set, else the raw values.
  - neg = is_signed & (a[MSB] ^ b[MSB]) is stored.
  - Accumulator is cleared, counter=0, busy<=1, state goes to RUN.
- Ignored start: start=1 while busy=1 is ignored; it is not queued. start is level-sampled, so holding it high in IDLE starts back-to-back operations.
- RUN step: each edge performs one unsigned shift-add step.
  - If the multiplier LSB is 1, add the multiplicand magnitude to the upper half of a (2*WIDTH+1)-bit accumulator; the carry is kept.
  - Shift the accumulator right by 1.
  - Shift the multiplier register right by 1.
  - counter += 1.
- Completion: on the edge where counter==WIDTH-1, the final step completes and {hi,lo} <= neg ? -(accumulator) : accumulator, using 2*WIDTH-bit two's-complement negation. On the same edge busy<=0 and done<=1. done falls on the next edge.
- Latency: start accepted at edge N; busy=1 after N through N+WIDTH-1; result and done visible after edge N+WIDTH (32 cycles at default).
- hi/lo hold the previous product unchanged throughout RUN. They change only at completion or reset.
- start=1 on the completion edge is ignored because busy was 1 before that edge. The earliest next acceptance is edge N+WIDTH+1, which gives a throughput of one op per WIDTH+1 cycles when start is held.
- Signed boundaries:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), an unsigned WIDTH-bit value, and must be handled correctly.
  - A zero operand with neg=1 yields 0, not a negative zero pattern.
- Reset mid-RUN aborts the operation: no done pulse, and hi/lo clear to 0.
- Operand inputs may change freely after the accepting edge without affecting the result.

Test Plan:
- Reset/idle: hold reset=0 with clocks running, then release -> busy=0, done=0, hi=lo=0; start=0 for 40 cycles -> nothing changes.
- Unsigned max: is_signed=0, a=b=0xFFFFFFFF -> after exactly 32 edges, done pulses once with {hi,lo}=0xFFFFFFFE_00000001; busy is high for exactly 32 cycles.
- Signed corners:
  - a=0x80000000, b=0x80000000 -> {hi,lo}=0x40000000_00000000.
  - a=0x80000000, b=1 -> 0xFFFFFFFF_80000000.
  - a=-7, b=6 -> 0xFFFFFFFF_FFFFFFD6.
  - a=0, b=-5 -> 0.
- Handshake:
  - Pulse start with operands 3x5, change a/b to garbage the next cycle, and assert start mid-RUN -> result 15, the mid-RUN start is ignored, and hi/lo keep their prior value until done.
  - Hold start high -> second op accepted at edge N+33.
- Reset mid-operation: start 0x12345678*0x9ABCDEF0, assert reset=0 asynchronously (between edges) at cycle 10 -> busy and hi/lo clear immediately, no done; a new op after release computes correctly.
- Random: 1000 random signed/unsigned operand pairs checked against a 64-bit reference model, including the back-to-back start case.
